muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU
//  on the two register-bank read operands (rs, rt) and holds the results in HI/LO.
//  HI/LO are then written back to the register bank through MFHI/MFLO.
//  The control unit stalls on busy and uses the done pulse to release dependent instructions.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring-divide step per cycle; signs are handled on magnitudes.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO accepted
// RUN   | WIDTH iterations of shift-add or restoring division
// FIX   | sign correction and HI/LO commit; done pulses next cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        count;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 zero_div;
  logic [WIDTH-1:0]     a_raw;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_upper, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    a_neg = ~op[0] & rs_data[WIDTH-1];
    b_neg = ~op[0] & rt_data[WIDTH-1];
    a_mag = a_neg ? (~rs_data + 1'b1) : rs_data;
    b_mag = b_neg ? (~rt_data + 1'b1) : rt_data;
  end

  // Multiply: accumulator upper half gathers partial sums, lower half shifts out multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the bottom.
  always_comb begin
    div_upper = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_upper - {1'b0, mcand};
    div_ge    = ~div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_upper[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      a_raw       <= '0;
      mcand       <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_div <= op[1] & (rt_data == '0);
            a_raw    <= rs_data;
            if (op[1]) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              mcand <= b_mag;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              mcand <= a_mag;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          if (zero_div) begin
            lo <= '1;
            hi <= a_raw;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// divide-by-zero, back-to-back starts, mid-operation reset and MTHI/MTLO priority.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wdata;
  logic         hi_we, lo_we;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and returns in the done cycle (or after the cycle budget).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    step();
    start = 1'b0; op = ~o; rs_data = ~a; rt_data = 32'h1357_9bdf;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  typedef struct {
    string        tag;
    logic [1:0]   o;
    logic [W-1:0] a, b, hi_exp, lo_exp;
    logic         dbz_exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cyc;
    int dones;
    int first_k, second_k;
    logic [W-1:0] first_lo, second_lo;

    rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // MULTU latency and busy.
    start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    step();
    start = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (cyc == 16) chk("hi_stable_run", hi, 0);
      step();
      cyc++;
    end
    chk("multu_latency", cyc, 33);
    chk("multu_busy_done", busy, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    step();
    chk("done_one_cycle", done, 0);

    vecs.push_back('{"mult_m3x7",   2'b00, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{"div_m7d2",    2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"div_7dm2",    2'b10, 32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{"divu_100d7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    vecs.push_back('{"divu_100d0",  2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"div_m7d0",    2'b10, -32'sd7, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0});
    vecs.push_back('{"mult_min2",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0});
    vecs.push_back('{"multu_big",   2'b01, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001, 32'h8000_0000, 1'b0});
    vecs.push_back('{"mult_m1xm1",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0});

    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, cyc);
      chk({vecs[i].tag, "_done"}, done, 1);
      chk({vecs[i].tag, "_lat"}, cyc, 33);
      chk({vecs[i].tag, "_hi"}, hi, vecs[i].hi_exp);
      chk({vecs[i].tag, "_lo"}, lo, vecs[i].lo_exp);
      chk({vecs[i].tag, "_dbz"}, div_by_zero, vecs[i].dbz_exp);
    end
    step();

    // start held high for 80 cycles; operands change every cycle.
    dones = 0; first_k = -1; second_k = -1; first_lo = '0; second_lo = '0;
    for (int k = 0; k < 80; k++) begin
      start = 1'b1; op = 2'b01; rs_data = W'(k + 1); rt_data = 32'd3;
      step();
      if (done) begin
        dones++;
        if (dones == 1) begin first_k = k; first_lo = lo; end
        if (dones == 2) begin second_k = k; second_lo = lo; end
      end
    end
    start = 1'b0;
    chk("b2b_dones", dones, 2);
    chk("b2b_first_k", first_k, 33);
    chk("b2b_second_k", second_k, 67);
    chk("b2b_first_lo", first_lo, 32'd3);
    chk("b2b_second_lo", second_lo, 32'd105);

    // Reset mid-DIV (HI/LO currently non-zero from the MULTU above).
    rst = 1'b1; step(); rst = 1'b0;
    run_op(2'b01, 32'd9, 32'd9, cyc);
    step();
    start = 1'b1; op = 2'b10; rs_data = 32'd1000; rt_data = 32'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) dones++;
    end
    chk("midrst_nodone", dones, 0);
    lo_we = 1'b1; wdata = 32'h1234;
    step();
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_hi", hi, 0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi, 32'hA5A5_A5A5);
    chk("mthilo_lo", lo, 32'hA5A5_A5A5);

    // start + hi_we same cycle, then hi_we during RUN.
    start = 1'b1; op = 2'b01; rs_data = 32'h0001_0000; rt_data = 32'h0003_0000;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    start = 1'b0; wdata = 32'h5555_5555;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
      if (cyc == 5) chk("hiwe_run_hi", hi, 32'hA5A5_A5A5);
    end
    hi_we = 1'b0;
    chk("prio_done", done, 1);
    chk("prio_hi", hi, 32'h0000_0003);
    chk("prio_lo", lo, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
